// File: rtl/full_add_sub.sv
// -----------------------------------------------------------------------------
// full_add_sub
//
// Registered full adder / full subtractor of parameterisable width. A ripple
// chain of WIDTH single-bit cells computes a + b + cin (en=1) or
// a - b - cin (en=0). The chain result is steered into either the add outputs
// or the subtract outputs and captured in one register stage, so no input has
// a combinational path to any output.
//
// Parameters
//   WIDTH  operand/result width in bits (>= 1)
//
// Ports
//   clk     rising-edge clock
//   rst     synchronous, active-high reset (clears all outputs)
//   a       operand A (minuend in subtract mode)
//   b       operand B (subtrahend in subtract mode)
//   cin     carry-in (add) / borrow-in (subtract)
//   en      mode select: 1 = add, 0 = subtract
//   sum     registered sum        (add mode, else 0)
//   carry   registered carry-out  (add mode, else 0)
//   diff    registered difference (subtract mode, else 0)
//   borrow  registered borrow-out (subtract mode, else 0)
// -----------------------------------------------------------------------------
module full_add_sub #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             en,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    // chain[i] is the carry/borrow into bit i; chain[WIDTH] is the final out.
    logic [WIDTH:0]   chain;
    logic [WIDTH-1:0] result;

    assign chain[0] = cin;

    // The result bit is a^b^cin in both modes; only the chain term differs.
    // Borrow out of a subtractor cell is ~a&b | bin&~(a^b).
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic prop;
        assign prop          = a[i] ^ b[i];
        assign result[i]     = prop ^ chain[i];
        assign chain[i+1]    = en ? ((a[i] & b[i])  | (chain[i] & prop))
                                  : ((~a[i] & b[i]) | (chain[i] & ~prop));
    end

    logic [WIDTH-1:0] sum_d,    sum_q;
    logic             carry_d,  carry_q;
    logic [WIDTH-1:0] diff_d,   diff_q;
    logic             borrow_d, borrow_q;

    // NOTE: every output of this block gets a default before the mode branch,
    // so no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        sum_d    = '0;
        carry_d  = 1'b0;
        diff_d   = '0;
        borrow_d = 1'b0;
        if (en) begin
            sum_d   = result;
            carry_d = chain[WIDTH];
        end else begin
            diff_d   = result;
            borrow_d = chain[WIDTH];
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q    <= '0;
            carry_q  <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign sum    = sum_q;
    assign carry  = carry_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_full_add_sub.sv
// -----------------------------------------------------------------------------
// tb_full_add_sub
//
// Drives a WIDTH=1 and a WIDTH=4 instance of full_add_sub from shared stimulus
// (the 1-bit instance sees bit 0 of the operands). An arithmetic reference
// model predicts both instances each cycle and a compare process checks them
// on the falling edge; directed vectors add hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_full_add_sub;

    typedef struct packed {
        logic [3:0] sum;
        logic       carry;
        logic [3:0] diff;
        logic       borrow;
    } res_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] a, b;
    logic       cin, en;

    logic [0:0] sum1, diff1;
    logic       carry1, borrow1;
    logic [3:0] sum4, diff4;
    logic       carry4, borrow4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    full_add_sub #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .a(a[0:0]), .b(b[0:0]), .cin(cin), .en(en),
        .sum(sum1), .carry(carry1), .diff(diff1), .borrow(borrow1)
    );

    full_add_sub #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .en(en),
        .sum(sum4), .carry(carry4), .diff(diff4), .borrow(borrow4)
    );

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Plain unsigned arithmetic on integers, reduced modulo 2^w.
    function automatic res_t model(input int w, input int av, input int bv,
                                   input int cv, input bit ev);
        res_t r;
        int   m;
        int   t;
        r = '0;
        m = 1 << w;
        av = av % m;
        bv = bv % m;
        if (ev) begin
            t       = av + bv + cv;
            r.sum   = 4'(t % m);
            r.carry = (t >= m);
        end else begin
            t        = av - bv - cv;
            r.diff   = 4'((t + 2 * m) % m);
            r.borrow = (av < bv + cv);
        end
        return r;
    endfunction

    res_t exp1, exp4;
    bit   model_valid = 1'b0;

    always @(posedge clk) begin
        model_valid <= 1'b1;
        if (rst) begin
            exp1 <= '0;
            exp4 <= '0;
        end else begin
            exp1 <= model(1, int'(a), int'(b), int'(cin), en);
            exp4 <= model(4, int'(a), int'(b), int'(cin), en);
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("m1_sum",    int'(sum1),    int'(exp1.sum[0]));
            check("m1_carry",  int'(carry1),  int'(exp1.carry));
            check("m1_diff",   int'(diff1),   int'(exp1.diff[0]));
            check("m1_borrow", int'(borrow1), int'(exp1.borrow));
            check("m4_sum",    int'(sum4),    int'(exp4.sum));
            check("m4_carry",  int'(carry4),  int'(exp4.carry));
            check("m4_diff",   int'(diff4),   int'(exp4.diff));
            check("m4_borrow", int'(borrow4), int'(exp4.borrow));
        end
    end

    // Drive one operation on the falling edge, then return 1 time unit after
    // the rising edge that registers it.
    task automatic apply(input bit r, input int av, input int bv,
                         input bit cv, input bit ev);
        @(negedge clk);
        rst = r;
        a   = 4'(av);
        b   = 4'(bv);
        cin = cv;
        en  = ev;
        @(posedge clk);
        #1;
    endtask

    task automatic lit1(input string name, input int s, input int c,
                        input int d, input int bo);
        check({name, "_sum"},    int'(sum1),    s);
        check({name, "_carry"},  int'(carry1),  c);
        check({name, "_diff"},   int'(diff1),   d);
        check({name, "_borrow"}, int'(borrow1), bo);
    endtask

    task automatic lit4(input string name, input int s, input int c,
                        input int d, input int bo);
        check({name, "_sum"},    int'(sum4),    s);
        check({name, "_carry"},  int'(carry4),  c);
        check({name, "_diff"},   int'(diff4),   d);
        check({name, "_borrow"}, int'(borrow4), bo);
    endtask

    initial begin
        rst = 1'b1; a = '0; b = '0; cin = 1'b0; en = 1'b1;

        // Reset discards an active add; release registers it.
        apply(1, 1, 1, 1, 1); lit1("rst1", 0, 0, 0, 0); lit4("rst4", 0, 0, 0, 0);
        apply(0, 1, 1, 1, 1); lit1("rel",  1, 1, 0, 0);

        // 1-bit add truth table.
        apply(0, 0, 0, 0, 1); lit1("add000", 0, 0, 0, 0);
        apply(0, 0, 0, 1, 1); lit1("add001", 1, 0, 0, 0);
        apply(0, 0, 1, 0, 1); lit1("add010", 1, 0, 0, 0);
        apply(0, 0, 1, 1, 1); lit1("add011", 0, 1, 0, 0);

        // 1-bit subtract truth table.
        apply(0, 1, 0, 0, 0); lit1("sub100", 0, 0, 1, 0);
        apply(0, 1, 0, 1, 0); lit1("sub101", 0, 0, 0, 0);
        apply(0, 1, 1, 0, 0); lit1("sub110", 0, 0, 0, 0);
        apply(0, 1, 1, 1, 0); lit1("sub111", 0, 0, 1, 1);
        apply(0, 0, 1, 0, 0); lit1("sub010", 0, 0, 1, 1);

        // Mode toggle: inactive outputs clear on the very next cycle.
        apply(0, 0, 1, 1, 1); lit1("tog_add", 0, 1, 0, 0);
        apply(0, 0, 1, 1, 0); lit1("tog_sub", 0, 0, 0, 1);
        apply(0, 0, 1, 1, 1); lit1("tog_add2", 0, 1, 0, 0);

        // 4-bit boundaries.
        apply(0, 15, 15, 1, 1); lit4("w_add_max", 15, 1, 0, 0);
        apply(0, 0, 15, 1, 0);  lit4("w_sub_min", 0, 0, 0, 1);
        apply(0, 9, 4, 0, 0);   lit4("w_sub_9_4", 0, 0, 5, 0);
        apply(0, 15, 0, 0, 0);  lit4("w_sub_15_0", 0, 0, 15, 0);

        // Exhaustive sweep; the compare process checks every cycle.
        for (int e = 0; e < 2; e++)
            for (int c = 0; c < 2; c++)
                for (int i = 0; i < 16; i++)
                    for (int j = 0; j < 16; j++)
                        apply(0, i, j, c[0], e[0]);

        // Reset mid-stream, then recovery.
        apply(1, 15, 15, 1, 1); lit4("rst_mid", 0, 0, 0, 0);
        apply(0, 3, 5, 1, 0);   lit4("post_rst", 0, 0, 13, 1);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
